// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sits between the system PLL and the downstream clock domains. It pulses
//   the PLL reset, waits for lock, debounces the lock indication, then releases
//   the per-domain resets one at a time with a fixed spacing. A lock timeout
//   re-resets the PLL; too many timeouts latch a hard failure that only a
//   software restart clears. Loss of lock in RUN restarts the whole sequence.
//
// Ports
//   refclk          : reference clock, the only clock in this block
//   rst             : asynchronous active-high reset
//   locked          : PLL lock, asynchronous to refclk (2-flop synchronized)
//   sw_reset_req    : single-cycle request for a full restart
//   pll_rst         : PLL reset, active-high
//   stage_rst       : per-domain resets, active-high, released in order 0..N-1
//   ready           : every stage released and PLL locked
//   lock_fail       : retry budget exhausted
//   retry_count     : failed lock attempts since last RUN entry or FAIL exit
//   lock_loss_count : saturating count of lock losses seen in RUN
//
// MAX_RETRIES must be in 1..7 so that it fits the 3-bit retry counter.

module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 64,
  parameter int NUM_STAGES          = 4,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic                  lock_fail,
  output logic [2:0]            retry_count,
  output logic [7:0]            lock_loss_count
);

  // One shared timer, sized for the longest interval it has to count.
  localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int TMAX_B = (LOCK_FILTER_CYCLES > STAGE_GAP_CYCLES) ? LOCK_FILTER_CYCLES : STAGE_GAP_CYCLES;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [TW-1:0] T_PLL  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_FILT = TW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(STAGE_GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST   = IW'(NUM_STAGES - 1);
  localparam logic [2:0]    RLIM   = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_FILTER,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic [1:0]    sync_pipe;
  logic          locked_s;
  logic [2:0]    retry_nxt;

  assign locked_s  = sync_pipe[1];
  assign retry_nxt = retry_count + 3'd1;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_pipe       <= '0;
      state           <= S_PLL_RESET;
      timer           <= '0;
      idx             <= '0;
      pll_rst         <= 1'b1;
      stage_rst       <= '1;
      ready           <= 1'b0;
      lock_fail       <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], locked};

      // Counting states advance the timer; every transition below reloads it.
      if (state != S_RUN && state != S_FAIL) timer <= timer + 1'b1;

      if (sw_reset_req) begin
        // Software restart outranks any lock event in the same cycle and is
        // never counted as a retry or a loss.
        state     <= S_PLL_RESET;
        timer     <= '0;
        pll_rst   <= 1'b1;
        stage_rst <= '1;
        ready     <= 1'b0;
        if (state == S_FAIL) begin
          retry_count <= '0;
          lock_fail   <= 1'b0;
        end
      end else begin
        case (state)
          S_PLL_RESET: begin
            if (timer == T_PLL) begin
              state   <= S_WAIT_LOCK;
              timer   <= '0;
              pll_rst <= 1'b0;
            end
          end

          S_WAIT_LOCK: begin
            if (locked_s) begin
              state <= S_FILTER;
              timer <= '0;
            end else if (timer == T_LOCK) begin
              retry_count <= retry_nxt;
              timer       <= '0;
              pll_rst     <= 1'b1;
              if (retry_nxt == RLIM) begin
                state     <= S_FAIL;
                lock_fail <= 1'b1;
              end else begin
                state <= S_PLL_RESET;
              end
            end
          end

          S_FILTER: begin
            // A glitch restarts the wait with a fresh timeout; not a retry.
            if (!locked_s) begin
              state <= S_WAIT_LOCK;
              timer <= '0;
            end else if (timer == T_FILT) begin
              state <= S_RELEASE;
              timer <= '0;
              idx   <= '0;
            end
          end

          S_RELEASE: begin
            // Lock drop wins over a coincident release, so RUN is never
            // entered on an unlocked PLL. Released stages all go back to reset.
            if (!locked_s) begin
              state     <= S_WAIT_LOCK;
              timer     <= '0;
              stage_rst <= '1;
            end else if (timer == T_GAP) begin
              stage_rst[idx] <= 1'b0;
              timer          <= '0;
              if (idx == LAST) begin
                state       <= S_RUN;
                ready       <= 1'b1;
                retry_count <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end

          S_RUN: begin
            if (!locked_s) begin
              if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
              state     <= S_PLL_RESET;
              timer     <= '0;
              pll_rst   <= 1'b1;
              stage_rst <= '1;
              ready     <= 1'b0;
            end
          end

          S_FAIL: begin
            // Parked with the PLL held in reset; only sw_reset_req leaves.
          end

          default: begin
            state     <= S_PLL_RESET;
            timer     <= '0;
            pll_rst   <= 1'b1;
            stage_rst <= '1;
            ready     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
  localparam int PRC = 4, LTC = 100, LFC = 8, GAP = 4, NS = 4, MR = 2;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          locked = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic          pll_rst;
  logic [NS-1:0] stage_rst;
  logic          ready;
  logic          lock_fail;
  logic [2:0]    retry_count;
  logic [7:0]    lock_loss_count;
  logic [17:0]   dut_out;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(LTC), .LOCK_FILTER_CYCLES(LFC),
    .STAGE_GAP_CYCLES(GAP), .NUM_STAGES(NS), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .sw_reset_req(sw_reset_req),
    .pll_rst(pll_rst), .stage_rst(stage_rst), .ready(ready), .lock_fail(lock_fail),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  assign dut_out = {pll_rst, stage_rst, ready, lock_fail, retry_count, lock_loss_count};

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h  (pll,stg,rdy,lf,rc,llc) t=%0t", name, got, want, $time);
  endtask

  // Reference model: phase plus cycles elapsed in that phase; outputs are
  // derived from the phase and elapsed time alone.
  localparam int P_RST = 0, P_WAIT = 1, P_FILT = 2, P_REL = 3, P_RUN = 4, P_FAIL = 5;
  int m_ph, m_e, m_rc, m_llc;
  bit lk_d1, lk_d2;
  bit chk_model = 0;

  task automatic model_reset();
    m_ph = P_RST; m_e = 0; m_rc = 0; m_llc = 0; lk_d1 = 0; lk_d2 = 0;
  endtask

  task automatic go(input int ph);
    m_ph = ph; m_e = 0;
  endtask

  task automatic model_step(input bit lk, input bit sw);
    bit ls;
    ls = lk_d2; lk_d2 = lk_d1; lk_d1 = lk;
    if (sw) begin
      if (m_ph == P_FAIL) m_rc = 0;
      go(P_RST);
    end else begin
      case (m_ph)
        P_RST: begin m_e++; if (m_e == PRC) go(P_WAIT); end
        P_WAIT: if (ls) go(P_FILT);
                else begin
                  m_e++;
                  if (m_e == LTC) begin m_rc++; go((m_rc == MR) ? P_FAIL : P_RST); end
                end
        P_FILT: if (!ls) go(P_WAIT); else begin m_e++; if (m_e == LFC) go(P_REL); end
        P_REL:  if (!ls) go(P_WAIT);
                else begin m_e++; if (m_e == NS*GAP) begin m_rc = 0; go(P_RUN); end end
        P_RUN:  if (!ls) begin if (m_llc < 255) m_llc++; go(P_RST); end
        default: ;
      endcase
    end
  endtask

  function automatic logic [17:0] model_out();
    logic [3:0] stg;
    stg = 4'hF;
    if (m_ph == P_RUN) stg = 4'h0;
    else if (m_ph == P_REL) stg = 4'hF << (m_e / GAP);
    return {(m_ph == P_RST || m_ph == P_FAIL), stg, (m_ph == P_RUN), (m_ph == P_FAIL),
            3'(m_rc), 8'(m_llc)};
  endfunction

  task automatic tick();
    @(posedge refclk);
    if (!rst) model_step(locked, sw_reset_req);
    @(negedge refclk);
    if (chk_model) check("model", dut_out, model_out());
  endtask

  task automatic do_reset(input bit lk);
    @(negedge refclk);
    rst = 1; locked = lk; sw_reset_req = 0;
    model_reset();
    tick(); tick();
    rst = 0;
  endtask

  task automatic wait_ready(input bit lvl, input string name, output bit ok);
    int t;
    t = 0;
    while (ready !== lvl && t < 200) begin tick(); t++; end
    ok = (ready === lvl);
    if (!ok) begin
      n_chk++;
      $display("FAIL %s: ready=%b after %0d cycles, expected %b", name, ready, t, lvl);
    end
  endtask

  task automatic wait_stg(input logic [3:0] v, input string name, output bit ok);
    int t;
    t = 0;
    while (stage_rst !== v && t < 200) begin tick(); t++; end
    ok = (stage_rst === v);
    if (!ok) begin
      n_chk++;
      $display("FAIL %s: stage_rst=%b after %0d cycles, expected %b", name, stage_rst, t, v);
    end
  endtask

  typedef struct {
    int         n;
    bit         do_rst;
    bit         lk;
    bit         sw;
    logic [17:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(int n, bit r, bit lk, bit sw, bit p, logic [3:0] s,
                             bit rd, bit lf, int rc, int llc);
    vec_t x;
    x.n = n; x.do_rst = r; x.lk = lk; x.sw = sw;
    x.exp = {p, s, rd, lf, 3'(rc), 8'(llc)};
    return x;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int seg;

    // Nominal bring-up (locked raised after cycle 10), then a 1-cycle lock loss.
    vt.push_back(v( 0,1,0,0, 1,4'hF,0,0,0,0));
    vt.push_back(v( 3,0,0,0, 1,4'hF,0,0,0,0));
    vt.push_back(v( 1,0,0,0, 0,4'hF,0,0,0,0));
    vt.push_back(v( 6,0,0,0, 0,4'hF,0,0,0,0));
    vt.push_back(v(14,0,1,0, 0,4'hF,0,0,0,0));
    vt.push_back(v( 1,0,1,0, 0,4'hE,0,0,0,0));
    vt.push_back(v( 3,0,1,0, 0,4'hE,0,0,0,0));
    vt.push_back(v( 1,0,1,0, 0,4'hC,0,0,0,0));
    vt.push_back(v( 4,0,1,0, 0,4'h8,0,0,0,0));
    vt.push_back(v( 3,0,1,0, 0,4'h8,0,0,0,0));
    vt.push_back(v( 1,0,1,0, 0,4'h0,1,0,0,0));
    vt.push_back(v( 5,0,1,0, 0,4'h0,1,0,0,0));
    vt.push_back(v( 1,0,0,0, 0,4'h0,1,0,0,0));
    vt.push_back(v( 1,0,1,0, 0,4'h0,1,0,0,0));
    vt.push_back(v( 1,0,1,0, 1,4'hF,0,0,0,1));
    vt.push_back(v(29,0,1,0, 0,4'h0,1,0,0,1));
    // Filter glitch: 5 high, 1 low, then high; filter must restart.
    vt.push_back(v( 0,1,0,0, 1,4'hF,0,0,0,0));
    vt.push_back(v( 6,0,0,0, 0,4'hF,0,0,0,0));
    vt.push_back(v( 5,0,1,0, 0,4'hF,0,0,0,0));
    vt.push_back(v( 1,0,0,0, 0,4'hF,0,0,0,0));
    vt.push_back(v( 1,0,1,0, 0,4'hF,0,0,0,0));
    vt.push_back(v(13,0,1,0, 0,4'hF,0,0,0,0));
    vt.push_back(v( 1,0,1,0, 0,4'hE,0,0,0,0));
    // Two timeouts -> FAIL, locked ignored, sw_reset_req exits.
    vt.push_back(v(  0,1,0,0, 1,4'hF,0,0,0,0));
    vt.push_back(v(103,0,0,0, 0,4'hF,0,0,0,0));
    vt.push_back(v(  1,0,0,0, 1,4'hF,0,0,1,0));
    vt.push_back(v(  3,0,0,0, 1,4'hF,0,0,1,0));
    vt.push_back(v(  1,0,0,0, 0,4'hF,0,0,1,0));
    vt.push_back(v( 99,0,0,0, 0,4'hF,0,0,1,0));
    vt.push_back(v(  1,0,0,0, 1,4'hF,0,1,2,0));
    vt.push_back(v( 20,0,1,0, 1,4'hF,0,1,2,0));
    vt.push_back(v(  1,0,1,1, 1,4'hF,0,0,0,0));
    vt.push_back(v(  3,0,1,0, 1,4'hF,0,0,0,0));
    vt.push_back(v(  1,0,1,0, 0,4'hF,0,0,0,0));

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].do_rst) do_reset(vt[i].lk);
      locked = vt[i].lk; sw_reset_req = vt[i].sw;
      repeat (vt[i].n) tick();
      sw_reset_req = 0;
      check($sformatf("vec%0d", i), dut_out, vt[i].exp);
    end

    // Randomized lock behaviour and restarts against the model.
    do_reset(0);
    chk_model = 1;
    seg = 0;
    for (int c = 0; c < 6000; c++) begin
      if (seg == 0) begin
        if ($urandom_range(0, 3) != 0) begin
          locked = 1; seg = int'($urandom_range(1, 120));
        end else begin
          locked = 0;
          seg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 260));
        end
      end
      seg--;
      sw_reset_req = ($urandom_range(0, 299) == 0);
      tick();
    end
    sw_reset_req = 0;

    // 300 lock losses in RUN: counter saturates at 255.
    do_reset(1);
    for (int k = 0; k < 300; k++) begin
      wait_ready(1'b1, "sat_up", ok);
      if (!ok) break;
      locked = 0; tick(); locked = 1;
      wait_ready(1'b0, "sat_down", ok);
      if (!ok) break;
    end
    check("llc_saturate", 18'(lock_loss_count), 18'd255);

    // sw_reset_req on the same edge locked_s falls in RUN: loss not counted.
    do_reset(1);
    wait_ready(1'b1, "sim_up1", ok);
    locked = 0; tick(); locked = 1;
    wait_ready(1'b0, "sim_down1", ok);
    wait_ready(1'b1, "sim_up2", ok);
    locked = 0; tick(); locked = 1; tick();
    sw_reset_req = 1; tick(); sw_reset_req = 0;
    check("simul_edge", dut_out, {1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 8'd1});
    repeat (3) tick();
    check("simul_llc_hold", 18'(lock_loss_count), 18'd1);

    // Async reset between edges while stage_rst = 1100.
    wait_stg(4'b1100, "async_pre", ok);
    #2 rst = 1;
    model_reset();
    #1 check("async_rst", dut_out, {1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 8'd0});
    tick();
    rst = 0;
    tick();
    chk_model = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
